vga_timing_ctrl: RTL and testbench

//  Sequences 640x480@60 Hz raster timing in the PCLK domain (25.2 MHz from clock_480p).

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_timing_ctrl_sync_delay_line.sv | 41 ++++
 rtl/vga_timing_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, derived sync windows and controller state type.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vga_timing_ctrl_sync_delay_line.sv
// Fixed-depth shift line for {HSYNC,VSYNC,DE}; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             PCLK,
    input  logic             RESET_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge PCLK or negedge RESET_n) begin
            if (!RESET_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RESET_VAL;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: frame-atomic run/drain FSM, X/Y counters, sync decode.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_LAT = 2
) (
    input  logic             PCLK,
    input  logic             RESET_n,
    input  logic             EN,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             PIX_REQ,
    output logic             LINE_START,
    output logic             FRAME_START,
    output logic             VBLANK,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic             BUSY
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA_W   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_W   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_S   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_S   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [2:0] DEC_RST = {~HS_POL, ~VS_POL, 1'b0};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] x_nxt, y_nxt;
    logic             pix_req_q, pix_req_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_q, vblank_d;
    logic             busy_q, busy_d;
    logic [2:0]       dec_q, dec_d;
    logic [2:0]       dly_out;
    logic             x_end, frame_end, run_d, hs_on, vs_on;

    always_comb begin
        x_end     = (x_q == H_LAST);
        frame_end = x_end && (y_q == V_LAST);
        x_nxt     = x_end ? '0 : x_q + CNT_W'(1);
        y_nxt     = y_q;
        if (x_end) begin
            y_nxt = frame_end ? '0 : y_q + CNT_W'(1);
        end

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (EN) state_d = ST_RUN;
            end
            ST_RUN: begin
                x_d = x_nxt;
                y_d = y_nxt;
                if (!EN) state_d = frame_end ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                x_d = x_nxt;
                y_d = y_nxt;
                if (EN)             state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from next-cycle X/Y so they land registered with them.
        if (state_d == ST_IDLE) begin
            x_d = '0;
            y_d = '0;
        end
        run_d         = (state_d != ST_IDLE);
        pix_req_d     = run_d && (x_d < HA_W) && (y_d < VA_W);
        line_start_d  = run_d && (x_d == '0);
        frame_start_d = line_start_d && (y_d == '0);
        vblank_d      = run_d && (y_d >= VA_W);
        busy_d        = run_d;
        hs_on         = run_d && (x_d >= HS_S) && (x_d <= HS_E);
        vs_on         = run_d && (y_d >= VS_S) && (y_d <= VS_E);
        dec_d         = {hs_on ? HS_POL : ~HS_POL,
                         vs_on ? VS_POL : ~VS_POL,
                         pix_req_d};
    end

    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            pix_req_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            busy_q        <= 1'b0;
            dec_q         <= DEC_RST;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_req_q     <= pix_req_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            busy_q        <= busy_d;
            dec_q         <= dec_d;
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (DEC_RST)
    ) u_dly (
        .PCLK    (PCLK),
        .RESET_n (RESET_n),
        .din     (dec_q),
        .dout    (dly_out)
    );

    assign X           = x_q;
    assign Y           = y_q;
    assign PIX_REQ     = pix_req_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign VBLANK      = vblank_q;
    assign BUSY        = busy_q;
    assign {HSYNC, VSYNC, DE} = dly_out;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: two reduced-raster instances (latency 2 and 0) plus one full 480p instance.
module tb_vga_timing_ctrl;

    logic pclk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic en_f = 1'b0;

    always #5 pclk = ~pclk;

    logic [9:0] x, y, x0, y0, xf, yf;
    logic pix, ls, fs, vb, hs, vs, de, busy;
    logic pix0, ls0, fs0, vb0, hs0, vs0, de0, busy0;
    logic pixf, lsf, fsf, vbf, hsf, vsf, def, busyf;

    // Reduced raster: 16 px/line (hs 10..12), 11 lines/frame (vs 7..8).
    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2)
    ) dut (
        .PCLK(pclk), .RESET_n(rst_n), .EN(en),
        .X(x), .Y(y), .PIX_REQ(pix), .LINE_START(ls),
        .FRAME_START(fs), .VBLANK(vb), .HSYNC(hs),
        .VSYNC(vs), .DE(de), .BUSY(busy)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(0)
    ) dut0 (
        .PCLK(pclk), .RESET_n(rst_n), .EN(en),
        .X(x0), .Y(y0), .PIX_REQ(pix0), .LINE_START(ls0),
        .FRAME_START(fs0), .VBLANK(vb0), .HSYNC(hs0),
        .VSYNC(vs0), .DE(de0), .BUSY(busy0)
    );

    vga_timing_ctrl dutf (
        .PCLK(pclk), .RESET_n(rst_n), .EN(en_f),
        .X(xf), .Y(yf), .PIX_REQ(pixf), .LINE_START(lsf),
        .FRAME_START(fsf), .VBLANK(vbf), .HSYNC(hsf),
        .VSYNC(vsf), .DE(def), .BUSY(busyf)
    );

    typedef struct {
        int         adv;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [10:0] ef;
    } vec_t;

    vec_t tbl [18];

    localparam logic [10:0] IDLE_F = 11'b0000_110_0_110;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ex, ey, fs_cnt;

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // {pix,ls,fs,vb,hs,vs,de,busy} of dut, then {hs,vs,de} of dut0
    function automatic logic [10:0] flags();
        return {pix, ls, fs, vb, hs, vs, de, busy, hs0, vs0, de0};
    endfunction

    function automatic logic [76:0] rst_vec();
        return {x, y, flags(), x0, y0, xf, yf,
                busyf, hsf, vsf, def, pixf, fsf};
    endfunction

    localparam logic [76:0] RST_EXP =
        {10'd0, 10'd0, IDLE_F, 10'd0, 10'd0, 10'd0, 10'd0, 6'b011000};

    // Advance one cycle on the reduced raster, checking against a counter model.
    task automatic step_check(input string tag);
        logic hs_exp;
        tick();
        if (ex == 15) begin
            ex = 0;
            ey = (ey == 10) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
        hs_exp = (ex >= 10 && ex <= 12) ? 1'b0 : 1'b1;
        fs_cnt += int'(fs);
        check(tag, {x, y, fs, busy, hs0},
              {10'(ex), 10'(ey), 1'(ex == 0 && ey == 0), 1'b1, hs_exp});
    endtask

    initial begin
        int n, kf, hs_first, hs_low, de_cnt, ls_first, ls_second;
        int vcnt, dlines, per, bt;
        logic [9:0] vsx, vsy, bx, by;
        logic prev_de;

        tbl[0]  = '{1,  10'd0,  10'd0,  11'b1110_110_1_111};
        tbl[1]  = '{1,  10'd1,  10'd0,  11'b1000_110_1_111};
        tbl[2]  = '{1,  10'd2,  10'd0,  11'b1000_111_1_111};
        tbl[3]  = '{6,  10'd8,  10'd0,  11'b0000_111_1_110};
        tbl[4]  = '{2,  10'd10, 10'd0,  11'b0000_110_1_010};
        tbl[5]  = '{2,  10'd12, 10'd0,  11'b0000_010_1_010};
        tbl[6]  = '{1,  10'd13, 10'd0,  11'b0000_010_1_110};
        tbl[7]  = '{2,  10'd15, 10'd0,  11'b0000_110_1_110};
        tbl[8]  = '{1,  10'd0,  10'd1,  11'b1100_110_1_111};
        tbl[9]  = '{80, 10'd0,  10'd6,  11'b0101_110_1_110};
        tbl[10] = '{16, 10'd0,  10'd7,  11'b0101_110_1_100};
        tbl[11] = '{2,  10'd2,  10'd7,  11'b0001_100_1_100};
        tbl[12] = '{8,  10'd10, 10'd7,  11'b0001_100_1_000};
        tbl[13] = '{22, 10'd0,  10'd9,  11'b0101_100_1_110};
        tbl[14] = '{2,  10'd2,  10'd9,  11'b0001_110_1_110};
        tbl[15] = '{29, 10'd15, 10'd10, 11'b0001_110_1_110};
        tbl[16] = '{1,  10'd0,  10'd0,  11'b1110_110_1_111};
        tbl[17] = '{2,  10'd2,  10'd0,  11'b1000_111_1_111};

        #1 rst_n = 1'b0;
        #3;
        check("reset_state", 96'(rst_vec()), 96'(RST_EXP));
        repeat (2) @(posedge pclk);
        @(negedge pclk) rst_n = 1'b1;

        repeat (100) begin
            tick();
            check("idle_en0", 96'(rst_vec()), 96'(RST_EXP));
        end

        // Full 480p instance: first line timing.
        en_f = 1'b1;
        tick();
        check("f_first_run", {xf, yf, fsf, lsf, busyf},
              {10'd0, 10'd0, 3'b111});
        hs_first = -1; hs_low = 0; de_cnt = 0;
        ls_first = -1; ls_second = -1;
        for (kf = 1; kf <= 1600; kf++) begin
            tick();
            if (!hsf && hs_first < 0) hs_first = kf;
            if (!hsf && kf < 800) hs_low++;
            if (def && kf < 800) de_cnt++;
            if (lsf) begin
                if (ls_first < 0) ls_first = kf;
                else if (ls_second < 0) ls_second = kf;
            end
        end
        en_f = 1'b0;
        check("f_hsync_fall", 96'(hs_first), 96'(658));
        check("f_hsync_width", 96'(hs_low), 96'(96));
        check("f_de_per_line", 96'(de_cnt), 96'(640));
        check("f_line1_start", 96'(ls_first), 96'(800));
        check("f_line2_start", 96'(ls_second), 96'(1600));

        // Reduced raster vectors, EN=1 from idle.
        en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            repeat (tbl[i].adv) tick();
            check($sformatf("vec%0d", i), {x, y, flags()},
                  {tbl[i].ex, tbl[i].ey, tbl[i].ef});
        end

        n = 0;
        do begin
            tick();
            n++;
        end while (!fs && n < 400);
        check("wait_frame", 96'(n), 96'(174));

        prev_de = de; vcnt = 0; dlines = 0; per = 0;
        vsx = '0; vsy = '0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (!vs) begin
                if (vcnt == 0) begin
                    vsx = x;
                    vsy = y;
                end
                vcnt++;
            end
            if (de && !prev_de) dlines++;
            prev_de = de;
            if (fs) begin
                per = k;
                break;
            end
        end
        check("frame_period", 96'(per), 96'(176));
        check("vsync_width", 96'(vcnt), 96'(32));
        check("vsync_start_xy", {vsx, vsy}, {10'd2, 10'd7});
        check("de_lines", 96'(dlines), 96'(6));

        // Drop EN mid-frame: drain to end of frame.
        repeat (37) tick();
        check("pre_drain", {x, y, busy}, {10'd5, 10'd2, 1'b1});
        en = 1'b0;
        bt = 0; fs_cnt = 0; bx = '0; by = '0;
        while (busy && bt < 300) begin
            bx = x;
            by = y;
            tick();
            bt++;
            fs_cnt += int'(fs);
        end
        check("drain_cycles", 96'(bt), 96'(139));
        check("drain_last_xy", {bx, by}, {10'd15, 10'd10});
        check("drain_fs", 96'(fs_cnt), 96'(0));
        check("drain_idle", {x, y, busy}, {10'd0, 10'd0, 1'b0});
        repeat (5) tick();
        check("drain_settled", {x, y, flags()}, {10'd0, 10'd0, IDLE_F});

        // Drop and re-raise EN: raster must stay continuous.
        en = 1'b1;
        tick();
        check("t5_start", {x, y, fs, ls}, {10'd0, 10'd0, 2'b11});
        ex = 0; ey = 0; fs_cnt = 0;
        repeat (48) step_check("run_seq");
        en = 1'b0;
        repeat (48) step_check("drain_seq");
        en = 1'b1;
        repeat (100) step_check("rerun_seq");
        check("rerun_fs_count", 96'(fs_cnt), 96'(1));

        // EN low exactly on the last pixel while running.
        repeat (155) step_check("to_end_seq");
        en = 1'b0;
        tick();
        check("end_en_low", {x, y, busy, fs, ls},
              {10'd0, 10'd0, 3'b000});
        tick();
        check("end_idle", {x, y, flags()}, {10'd0, 10'd0, IDLE_F});

        // Mid-frame asynchronous reset.
        en = 1'b1;
        tick();
        repeat (84) tick();
        check("pre_reset", {x, y, pix, de}, {10'd4, 10'd5, 2'b11});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 96'(rst_vec()), 96'(RST_EXP));
        repeat (3) tick();
        check("reset_hold", 96'(rst_vec()), 96'(RST_EXP));
        en = 1'b0;
        @(negedge pclk) rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 96'(rst_vec()), 96'(RST_EXP));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
